riscv_core_div_ctrl: RTL and testbench

Multi-cycle sequencer for the RV64M divide/remainder unit in the execute stage. It accepts one DIV/DIVU/REM/REMU/DIVW/DIVUW/REMW/REMUW operation per handshake. It forms operand magnitudes, runs a radix-2 restoring shift-subtract loop one bit per cycle, applies sign correction, and holds the result until execute acknowledges it. Divide-by-zero and signed overflow bypass the loop.

---
 rtl/riscv_core_div_ctrl_if.sv | 27 ++
 rtl/riscv_core_div_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_riscv_core_div_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_core_div_ctrl_if.sv
// Request/response bundle between the execute stage (master) and the
// RV64M divide/remainder sequencer (slave).
interface riscv_core_div_ctrl_if #(
  parameter int XLEN = 64
);
  logic            valid;
  logic            ready;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [1:0]      control;
  logic            isword;
  logic            flush;
  logic            busy;
  logic            result_valid;
  logic [XLEN-1:0] result;
  logic            result_ack;

  modport master (
    output valid, src_a, src_b, control, isword, flush, result_ack,
    input  ready, busy, result_valid, result
  );

  modport slave (
    input  valid, src_a, src_b, control, isword, flush, result_ack,
    output ready, busy, result_valid, result
  );
endinterface

// File: rtl/riscv_core_div_ctrl.sv
// RV64M divide/remainder sequencer: radix-2 restoring shift-subtract, one
// quotient bit per cycle, with divide-by-zero and signed overflow resolved
// at accept time. control: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
module riscv_core_div_ctrl #(
  parameter int XLEN = 64
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  riscv_core_div_ctrl_if.slave  div_if
);

  localparam int HALF  = XLEN / 2;
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]  MIN_FULL = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  MIN_WORD = {{HALF{1'b0}}, 1'b1, {(HALF-1){1'b0}}};
  localparam logic [XLEN-1:0]  M1_WORD  = {{HALF{1'b0}}, {HALF{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  dividend_q;
  logic [XLEN-1:0]  divisor_q;
  logic [XLEN-1:0]  rem_q;
  logic             rem_sel_q;
  logic             word_q;
  logic             neg_quot_q;
  logic             neg_rem_q;
  logic [XLEN-1:0]  result_q;
  logic             ready_q;
  logic             busy_q;
  logic             valid_q;

  logic             req_signed;
  logic             req_rem;
  logic             req_word;
  logic [XLEN-1:0]  eff_a;
  logic [XLEN-1:0]  eff_b;
  logic [XLEN-1:0]  neg_a;
  logic [XLEN-1:0]  neg_b;
  logic [XLEN-1:0]  mag_a;
  logic [XLEN-1:0]  mag_b;
  logic             sign_a;
  logic             sign_b;
  logic             div_zero;
  logic             sgn_ovf;
  logic [XLEN-1:0]  special_result;

  logic [XLEN-1:0]  trial_low;
  logic [XLEN:0]    diff;
  logic             q_bit;
  logic [XLEN-1:0]  rem_next;
  logic [XLEN-1:0]  quot_next;
  logic [XLEN-1:0]  final_mag;
  logic             final_neg;
  logic [XLEN-1:0]  final_val;
  logic [XLEN-1:0]  final_result;

  // W results always carry bit HALF-1 sign-extended into the upper half.
  function automatic logic [XLEN-1:0] fmt_result(input logic [XLEN-1:0] v,
                                                 input logic            word);
    fmt_result = word ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
  endfunction

  assign req_signed = ~div_if.control[0];
  assign req_rem    = div_if.control[1];
  assign req_word   = div_if.isword;

  // Request decode: effective-width operands, magnitudes, signs and the loop-bypass cases.
  always_comb begin
    eff_a    = req_word ? {{HALF{1'b0}}, div_if.src_a[HALF-1:0]} : div_if.src_a;
    eff_b    = req_word ? {{HALF{1'b0}}, div_if.src_b[HALF-1:0]} : div_if.src_b;
    sign_a   = req_signed & (req_word ? div_if.src_a[HALF-1] : div_if.src_a[XLEN-1]);
    sign_b   = req_signed & (req_word ? div_if.src_b[HALF-1] : div_if.src_b[XLEN-1]);
    neg_a    = '0 - eff_a;
    neg_b    = '0 - eff_b;
    mag_a    = sign_a ? (req_word ? {{HALF{1'b0}}, neg_a[HALF-1:0]} : neg_a) : eff_a;
    mag_b    = sign_b ? (req_word ? {{HALF{1'b0}}, neg_b[HALF-1:0]} : neg_b) : eff_b;
    div_zero = (eff_b == '0);
    sgn_ovf  = req_signed &
               (req_word ? ((eff_a == MIN_WORD) && (eff_b == M1_WORD))
                         : ((eff_a == MIN_FULL) && (eff_b == '1)));
    if (div_zero) begin
      special_result = req_rem ? fmt_result(eff_a, req_word) : '1;
    end else begin
      special_result = req_rem ? '0 : fmt_result(eff_a, req_word);
    end
  end

  // One restoring step; the trial remainder needs XLEN+1 bits since rem can exceed 2^(XLEN-1).
  always_comb begin
    trial_low    = {rem_q[XLEN-2:0], dividend_q[XLEN-1]};
    diff         = {rem_q[XLEN-1], trial_low} - {1'b0, divisor_q};
    q_bit        = ~diff[XLEN];
    rem_next     = q_bit ? diff[XLEN-1:0] : trial_low;
    quot_next    = {dividend_q[XLEN-2:0], q_bit};
    final_mag    = rem_sel_q ? rem_next : quot_next;
    final_neg    = rem_sel_q ? neg_rem_q : neg_quot_q;
    final_val    = final_neg ? ('0 - final_mag) : final_mag;
    final_result = fmt_result(final_val, word_q);
  end

  // Sequencer FSM with registered handshake outputs; flush beats ack and loop completion.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      count      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      rem_sel_q  <= 1'b0;
      word_q     <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (div_if.valid && !div_if.flush) begin
            rem_sel_q  <= req_rem;
            word_q     <= req_word;
            neg_quot_q <= sign_a ^ sign_b;
            neg_rem_q  <= sign_a;
            dividend_q <= req_word ? (mag_a << HALF) : mag_a;
            divisor_q  <= mag_b;
            rem_q      <= '0;
            ready_q    <= 1'b0;
            if (div_zero || sgn_ovf) begin
              result_q <= special_result;
              count    <= '0;
              valid_q  <= 1'b1;
              state    <= S_DONE;
            end else begin
              count  <= req_word ? CNT_HALF : CNT_FULL;
              busy_q <= 1'b1;
              state  <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (div_if.flush) begin
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state   <= S_IDLE;
          end else begin
            dividend_q <= quot_next;
            rem_q      <= rem_next;
            if (count == '0) begin
              result_q <= final_result;
              busy_q   <= 1'b0;
              valid_q  <= 1'b1;
              state    <= S_DONE;
            end else begin
              count <= count - CNT_ONE;
            end
          end
        end
        S_DONE: begin
          if (div_if.flush || div_if.result_ack) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign div_if.ready        = ready_q;
  assign div_if.busy         = busy_q;
  assign div_if.result_valid = valid_q;
  assign div_if.result       = result_q;

endmodule

// File: tb/tb_riscv_core_div_ctrl.sv
// Self-checking bench for riscv_core_div_ctrl: directed vector table,
// multi-cycle corner sequences, and random operations against an
// arithmetic reference model.
module tb_riscv_core_div_ctrl;

  localparam int XLEN = 64;
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp_result;
    int          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  riscv_core_div_ctrl_if #(.XLEN(XLEN)) dif ();

  riscv_core_div_ctrl #(.XLEN(XLEN)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .div_if (dif)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: quotient/remainder from plain signed/unsigned arithmetic plus the special-case rules.
  function automatic logic [63:0] ref_result(logic [1:0] op, logic word,
                                             logic [63:0] a, logic [63:0] b);
    bit          sgn = !op[0];
    bit          rem = op[1];
    int          sa32;
    int          sb32;
    longint      sa64;
    longint      sb64;
    logic [31:0] r32;
    logic [63:0] r64;
    if (word) begin
      sa32 = int'(a[31:0]);
      sb32 = int'(b[31:0]);
      if (b[31:0] == 32'h0) r32 = rem ? a[31:0] : 32'hFFFF_FFFF;
      else if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
        r32 = rem ? 32'h0 : a[31:0];
      else if (sgn) r32 = rem ? 32'(sa32 % sb32) : 32'(sa32 / sb32);
      else r32 = rem ? (a[31:0] % b[31:0]) : (a[31:0] / b[31:0]);
      return {{32{r32[31]}}, r32};
    end
    sa64 = longint'(a);
    sb64 = longint'(b);
    if (b == 64'h0) r64 = rem ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
      r64 = rem ? 64'h0 : a;
    else if (sgn) r64 = rem ? 64'(sa64 % sb64) : 64'(sa64 / sb64);
    else r64 = rem ? (a % b) : (a / b);
    return r64;
  endfunction

  // Reference latency: one cycle for bypass cases, else width plus one.
  function automatic int ref_latency(logic [1:0] op, logic word,
                                     logic [63:0] a, logic [63:0] b);
    bit sgn = !op[0];
    if (word) begin
      if (b[31:0] == 32'h0) return 1;
      if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    if (b == 64'h0) return 1;
    if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return 1;
    return 65;
  endfunction

  // Operand generator biased toward the interesting boundary values.
  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return {$urandom, $urandom};
      1:       return 64'($urandom_range(0, 20));
      2:       return 64'h0;
      3:       return 64'hFFFF_FFFF_FFFF_FFFF;
      4:       return 64'h8000_0000_0000_0000;
      5:       return 64'h0 - 64'($urandom_range(1, 20));
      default: return {$urandom, 32'h8000_0000};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%h required=0x%h", name, act, exp);
    end
  endtask

  // Present one request at a negedge and let it be accepted at the next posedge.
  task automatic applyStimulus(input logic [1:0] op, input logic word,
                               input logic [63:0] a, input logic [63:0] b,
                               output bit accepted);
    int guard = 0;
    @(negedge clk);
    while (!dif.ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!dif.ready) begin
      checkOutput("ready_timeout", 64'(dif.ready), 64'h1);
      accepted = 1'b0;
      return;
    end
    dif.valid   = 1'b1;
    dif.control = op;
    dif.isword  = word;
    dif.src_a   = a;
    dif.src_b   = b;
    @(posedge clk);
    #1;
    dif.valid   = 1'b0;
    dif.src_a   = {$urandom, $urandom};
    dif.src_b   = {$urandom, $urandom};
    dif.control = 2'($urandom_range(0, 3));
    dif.isword  = 1'($urandom_range(0, 1));
    accepted    = 1'b1;
  endtask

  // Count cycles from the accept edge until result_valid, watching output exclusivity.
  task automatic waitResult(output int lat, output bit overlap);
    lat = 1;
    overlap = 1'b0;
    forever begin
      if ((dif.ready && dif.result_valid) || (dif.busy && (dif.ready || dif.result_valid)))
        overlap = 1'b1;
      if (dif.result_valid || lat >= 300) break;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic ackResult(input string name);
    @(negedge clk);
    dif.result_ack = 1'b1;
    @(posedge clk);
    #1;
    dif.result_ack = 1'b0;
    checkOutput({name, "_ack_ready"}, 64'(dif.ready), 64'h1);
    checkOutput({name, "_ack_valid"}, 64'(dif.result_valid), 64'h0);
  endtask

  task automatic runOp(input string name, input logic [1:0] op, input logic word,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp_r, input int exp_lat);
    bit acc;
    bit overlap;
    int lat;
    applyStimulus(op, word, a, b, acc);
    if (!acc) return;
    waitResult(lat, overlap);
    checkOutput({name, "_result"}, dif.result, exp_r);
    checkOutput({name, "_latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({name, "_exclusive"}, 64'(overlap), 64'h0);
    ackResult(name);
  endtask

  vec_t vecs[15];

  initial begin
    bit          acc;
    bit          overlap;
    int          lat;
    int          pulses;
    logic [1:0]  op;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;

    vecs[0]  = '{OP_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[1]  = '{OP_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[2]  = '{OP_DIVU, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[3]  = '{OP_REMU, 1'b0, 64'd100, 64'd0, 64'd100, 1};
    vecs[4]  = '{OP_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'h8000_0000_0000_0000, 1};
    vecs[5]  = '{OP_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1};
    vecs[6]  = '{OP_DIV,  1'b1, 64'h1234_5678_FFFF_FFF9, 64'hDEAD_0000_0000_0002,
                 64'hFFFF_FFFF_FFFF_FFFD, 33};
    vecs[7]  = '{OP_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33};
    vecs[8]  = '{OP_DIV,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
                 64'hFFFF_FFFF_8000_0000, 1};
    vecs[9]  = '{OP_REM,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'h0, 1};
    vecs[10] = '{OP_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 65};
    vecs[11] = '{OP_REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
                 64'h7FFF_FFFF_FFFF_FFFE, 65};
    vecs[12] = '{OP_REM,  1'b1, 64'hABCD_0000_0000_0064, 64'h0000_0001_0000_0000, 64'd100, 1};
    vecs[13] = '{OP_DIV,  1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[14] = '{OP_REMU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h10, 64'hF, 33};

    dif.valid      = 1'b0;
    dif.flush      = 1'b0;
    dif.result_ack = 1'b0;
    dif.src_a      = '0;
    dif.src_b      = '0;
    dif.control    = 2'b00;
    dif.isword     = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", 64'(dif.ready), 64'h1);
    checkOutput("reset_busy", 64'(dif.busy), 64'h0);
    checkOutput("reset_valid", 64'(dif.result_valid), 64'h0);
    checkOutput("reset_result", dif.result, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b,
            vecs[i].exp_result, vecs[i].exp_lat);
    end

    // Result held without ack stays put, then ack frees the controller
    applyStimulus(OP_DIVU, 1'b0, 64'd1000, 64'd3, acc);
    waitResult(lat, overlap);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("hold_valid", 64'(dif.result_valid), 64'h1);
    checkOutput("hold_result", dif.result, 64'd333);
    checkOutput("hold_ready", 64'(dif.ready), 64'h0);
    ackResult("hold");

    // Flush in IDLE together with a request: request is not taken
    @(negedge clk);
    dif.valid   = 1'b1;
    dif.flush   = 1'b1;
    dif.control = OP_DIVU;
    dif.isword  = 1'b0;
    dif.src_a   = 64'd9;
    dif.src_b   = 64'd3;
    @(posedge clk);
    #1;
    dif.valid = 1'b0;
    dif.flush = 1'b0;
    checkOutput("idle_flush_ready", 64'(dif.ready), 64'h1);
    checkOutput("idle_flush_busy", 64'(dif.busy), 64'h0);

    // Flush at BUSY cycle 10: no result pulse afterwards
    applyStimulus(OP_DIV, 1'b0, 64'd1000, 64'd7, acc);
    repeat (9) @(posedge clk);
    @(negedge clk);
    dif.flush = 1'b1;
    @(posedge clk);
    #1;
    dif.flush = 1'b0;
    checkOutput("busy_flush_ready", 64'(dif.ready), 64'h1);
    checkOutput("busy_flush_busy", 64'(dif.busy), 64'h0);
    pulses = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (dif.result_valid) pulses++;
    end
    checkOutput("busy_flush_no_pulse", 64'(pulses), 64'h0);
    runOp("after_flush", OP_REM, 1'b0, 64'd1000, 64'd7, 64'd6, 65);

    // Flush on the loop's final cycle beats completion
    applyStimulus(OP_DIVU, 1'b1, 64'd500, 64'd7, acc);
    repeat (31) @(posedge clk);
    @(negedge clk);
    dif.flush = 1'b1;
    @(posedge clk);
    #1;
    dif.flush = 1'b0;
    checkOutput("last_flush_valid", 64'(dif.result_valid), 64'h0);
    checkOutput("last_flush_ready", 64'(dif.ready), 64'h1);

    // Flush in DONE drops result_valid
    applyStimulus(OP_DIVU, 1'b0, 64'd50, 64'd0, acc);
    checkOutput("done_flush_pre", 64'(dif.result_valid), 64'h1);
    @(negedge clk);
    dif.flush = 1'b1;
    dif.result_ack = 1'b1;
    @(posedge clk);
    #1;
    dif.flush = 1'b0;
    dif.result_ack = 1'b0;
    checkOutput("done_flush_valid", 64'(dif.result_valid), 64'h0);
    checkOutput("done_flush_ready", 64'(dif.ready), 64'h1);

    // Reset during BUSY discards the operation and clears the result
    applyStimulus(OP_DIV, 1'b0, 64'd12345, 64'd11, acc);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("midreset_ready", 64'(dif.ready), 64'h1);
    checkOutput("midreset_busy", 64'(dif.busy), 64'h0);
    checkOutput("midreset_valid", 64'(dif.result_valid), 64'h0);
    checkOutput("midreset_result", dif.result, 64'h0);

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      op   = 2'($urandom_range(0, 3));
      word = 1'($urandom_range(0, 1));
      a    = pick_operand();
      b    = pick_operand();
      runOp($sformatf("rand%0d", i), op, word, a, b,
            ref_result(op, word, a, b), ref_latency(op, word, a, b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
